// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
// Instruction-set constants shared by fetch/decode-side blocks.
//   - opcode values for branch and jump, the HALT encoding
//   - bit positions of the op / dir / off fields in a 9-bit instruction
//   - state encoding of the branch resolve FSM
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

   localparam int ISA_INSTR_W = 9;
   localparam int OP_MSB      = 8;
   localparam int OP_LSB      = 6;
   localparam int DIR_BIT     = 5;
   localparam int OFF_MSB     = 4;
   localparam int OFF_W       = 5;

   localparam logic [2:0]             OP_BRANCH  = 3'b110;
   localparam logic [2:0]             OP_JUMP    = 3'b111;
   localparam logic [ISA_INSTR_W-1:0] INSTR_HALT = 9'h000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      HALTED = 2'd2
   } br_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_if
// Bundle between fetch and the branch resolve unit.
//   fetch -> unit : if_pc, if_instr, stall, cond_flag
//   unit -> fetch : pc_in, branch, taken, target, jump_sign, start
//   unit -> decode: id_valid, id_instr, id_pc
// slave  : the branch resolve unit side
// master : the driving side (fetch / environment)
// -----------------------------------------------------------------------------
interface branch_resolve_unit_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 9
);
   logic [PC_W-1:0]    if_pc;
   logic [INSTR_W-1:0] if_instr;
   logic               stall;
   logic               cond_flag;

   logic [PC_W-1:0]    pc_in;
   logic               branch;
   logic               taken;
   logic [PC_W-1:0]    target;
   logic               jump_sign;
   logic               start;

   logic               id_valid;
   logic [INSTR_W-1:0] id_instr;
   logic [PC_W-1:0]    id_pc;

   modport slave (
      input  if_pc, if_instr, stall, cond_flag,
      output pc_in, branch, taken, target, jump_sign, start,
      output id_valid, id_instr, id_pc
   );

   modport master (
      output if_pc, if_instr, stall, cond_flag,
      input  pc_in, branch, taken, target, jump_sign, start,
      input  id_valid, id_instr, id_pc
   );
endinterface

// File: rtl/branch_decode.sv
// -----------------------------------------------------------------------------
// branch_decode
// Combinational classification of one fetched instruction.
//   instr_i     in   9  instruction word
//   cond_flag_i in   1  branch condition from execute
//   is_br_o     out  1  conditional branch or unconditional jump
//   is_taken_o  out  1  jump, or branch whose condition is true
//   off_o       out  5  offset magnitude
//   dir_o       out  1  1 = forward (add), 0 = backward (subtract)
//   is_halt_o   out  1  instruction word is the HALT encoding
// -----------------------------------------------------------------------------
module branch_decode
   import cpu_isa_pkg::*;
(
   input  logic [ISA_INSTR_W-1:0] instr_i,
   input  logic                   cond_flag_i,
   output logic                   is_br_o,
   output logic                   is_taken_o,
   output logic [OFF_W-1:0]       off_o,
   output logic                   dir_o,
   output logic                   is_halt_o
);
   logic [2:0] op;
   logic       is_cbr;
   logic       is_jmp;

   assign op         = instr_i[OP_MSB:OP_LSB];
   assign is_cbr     = (op == OP_BRANCH);
   assign is_jmp     = (op == OP_JUMP);
   assign is_br_o    = is_cbr | is_jmp;
   assign is_taken_o = is_jmp | (is_cbr & cond_flag_i);
   assign off_o      = instr_i[OFF_MSB:0];
   assign dir_o      = instr_i[DIR_BIT];
   assign is_halt_o  = (instr_i == INSTR_HALT);
endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Captures each fetched instruction and its PC, resolves branches / jumps /
// halt, drives the fetch redirect outputs and forwards live instructions to
// decode. After a taken redirect the next FLUSH_CYC captures are squashed;
// a HALT stops the machine until reset.
//   clk    in  single clock, all state on posedge
//   rst_n  in  synchronous active-low reset (priority over stall)
//   bus    slave side of branch_resolve_unit_if (fetch inputs, redirect and
//          decode outputs)
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import cpu_isa_pkg::*;
#(
   parameter int PC_W      = 16,
   parameter int INSTR_W   = 9,
   parameter int FLUSH_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_resolve_unit_if.slave  bus
);
   br_state_e          state_q, state_d;
   logic [1:0]         flush_cnt_q, flush_cnt_d;
   logic [PC_W-1:0]    pc_in_q, pc_in_d;
   logic               branch_q, branch_d;
   logic               taken_q, taken_d;
   logic [PC_W-1:0]    target_q, target_d;
   logic               jump_sign_q, jump_sign_d;
   logic               start_q, start_d;
   logic               id_valid_q, id_valid_d;
   logic [INSTR_W-1:0] id_instr_q, id_instr_d;
   logic [PC_W-1:0]    id_pc_q, id_pc_d;

   logic             dec_br, dec_taken, dec_dir, dec_halt;
   logic [OFF_W-1:0] dec_off;

   branch_decode u_decode (
      .instr_i     (bus.if_instr),
      .cond_flag_i (bus.cond_flag),
      .is_br_o     (dec_br),
      .is_taken_o  (dec_taken),
      .off_o       (dec_off),
      .dir_o       (dec_dir),
      .is_halt_o   (dec_halt)
   );

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pc_in_d     = pc_in_q;
      branch_d    = branch_q;
      taken_d     = taken_q;
      target_d    = target_q;
      jump_sign_d = jump_sign_q;
      // start is a pulse: it drops on any edge that is not a fresh halt capture
      start_d     = 1'b0;
      id_valid_d  = id_valid_q;
      id_instr_d  = id_instr_q;
      id_pc_d     = id_pc_q;

      if (!bus.stall) begin
         pc_in_d     = bus.if_pc;
         id_pc_d     = bus.if_pc;
         // squashed / halted slots look like an empty, non-branch slot
         id_valid_d  = 1'b0;
         id_instr_d  = '0;
         branch_d    = 1'b0;
         taken_d     = 1'b0;
         target_d    = '0;
         jump_sign_d = 1'b0;

         unique case (state_q)
            RUN: begin
               id_valid_d = 1'b1;
               id_instr_d = bus.if_instr;
               if (dec_br) begin
                  branch_d    = 1'b1;
                  taken_d     = dec_taken;
                  target_d    = {{(PC_W-OFF_W){1'b0}}, dec_off};
                  jump_sign_d = dec_dir;
               end
               if (dec_halt) begin
                  state_d = HALTED;
                  start_d = 1'b1;
               end else if (dec_taken) begin
                  state_d     = FLUSH;
                  flush_cnt_d = 2'(FLUSH_CYC);
               end
            end
            FLUSH: begin
               flush_cnt_d = flush_cnt_q - 2'd1;
               if (flush_cnt_q <= 2'd1) state_d = RUN;
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
         pc_in_q     <= '0;
         branch_q    <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         jump_sign_q <= 1'b0;
         start_q     <= 1'b0;
         id_valid_q  <= 1'b0;
         id_instr_q  <= '0;
         id_pc_q     <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         pc_in_q     <= pc_in_d;
         branch_q    <= branch_d;
         taken_q     <= taken_d;
         target_q    <= target_d;
         jump_sign_q <= jump_sign_d;
         start_q     <= start_d;
         id_valid_q  <= id_valid_d;
         id_instr_q  <= id_instr_d;
         id_pc_q     <= id_pc_d;
      end
   end

   assign bus.pc_in     = pc_in_q;
   assign bus.branch    = branch_q;
   assign bus.taken     = taken_q;
   assign bus.target    = target_q;
   assign bus.jump_sign = jump_sign_q;
   assign bus.start     = start_q;
   assign bus.id_valid  = id_valid_q;
   assign bus.id_instr  = id_instr_q;
   assign bus.id_pc     = id_pc_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scenario tasks drive rows of (reset, stall, cond, pc, instr) and push the
// output vector each row must produce; after the capture edge the vector is
// popped and compared with what the unit presents.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   typedef struct packed {
      logic        valid;
      logic [8:0]  instr;
      logic [15:0] pc;
      logic [15:0] pc_in;
      logic        br;
      logic        tk;
      logic [15:0] tgt;
      logic        js;
      logic        st;
   } out_t;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        cond;
      logic [15:0] pc;
      logic [8:0]  instr;
      out_t        exp;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   out_t sb_q[$];

   branch_resolve_unit_if #(.PC_W(16), .INSTR_W(9)) bus ();

   branch_resolve_unit #(.PC_W(16), .INSTR_W(9), .FLUSH_CYC(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   localparam out_t ZERO = '0;

   function automatic out_t mk(input logic v, input logic [8:0] i, input logic [15:0] pc,
                               input logic br, input logic tk, input logic [15:0] tgt,
                               input logic js, input logic st);
      out_t o;
      o.valid = v; o.instr = i; o.pc = pc; o.pc_in = pc;
      o.br = br; o.tk = tk; o.tgt = tgt; o.js = js; o.st = st;
      return o;
   endfunction

   function automatic stim_t S(input logic r, input logic s, input logic c,
                               input logic [15:0] pc, input logic [8:0] i, input out_t e);
      stim_t t;
      t.rst_n = r; t.stall = s; t.cond = c; t.pc = pc; t.instr = i; t.exp = e;
      return t;
   endfunction

   function automatic out_t observe();
      out_t o;
      o.valid = bus.id_valid; o.instr = bus.id_instr; o.pc = bus.id_pc;
      o.pc_in = bus.pc_in; o.br = bus.branch; o.tk = bus.taken;
      o.tgt = bus.target; o.js = bus.jump_sign; o.st = bus.start;
      return o;
   endfunction

   // drive one row, queue its expectation, advance past the capture edge
   task automatic drive(input stim_t s);
      rst_n         = s.rst_n;
      bus.stall     = s.stall;
      bus.cond_flag = s.cond;
      bus.if_pc     = s.pc;
      bus.if_instr  = s.instr;
      sb_q.push_back(s.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t rows[$];
      out_t got, exp;
      rows.push_back(S(1'b0, 1'b1, 1'b1, 16'($urandom), 9'($urandom), ZERO));
      rows.push_back(S(1'b0, 1'b0, 1'b1, 16'($urandom), 9'($urandom), ZERO));
      rows.push_back(S(1'b1, 1'b0, 1'b0, 16'h0005, 9'h045, mk(1, 9'h045, 16'h0005, 0, 0, 0, 0, 0)));
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_branch_taken();
      stim_t rows[$];
      out_t got, exp;
      rows.push_back(S(1, 0, 1, 16'h0010, 9'b110_0_00011, mk(1, 9'h183, 16'h0010, 1, 1, 16'd3, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0011, 9'h045, mk(0, 9'h000, 16'h0011, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0012, 9'h046, mk(1, 9'h046, 16'h0012, 0, 0, 0, 0, 0)));
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL branch_taken row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_branch_not_taken();
      stim_t rows[$];
      out_t got, exp;
      rows.push_back(S(1, 0, 0, 16'h0010, 9'b110_0_00011, mk(1, 9'h183, 16'h0010, 1, 0, 16'd3, 0, 0)));
      rows.push_back(S(1, 0, 1, 16'h0011, 9'h045, mk(1, 9'h045, 16'h0011, 0, 0, 0, 0, 0)));
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL branch_not_taken row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_jump_stall();
      stim_t rows[$];
      out_t got, exp, jmp;
      jmp = mk(1, 9'h1FF, 16'hFFF0, 1, 1, 16'd31, 1, 0);
      rows.push_back(S(1, 0, 0, 16'hFFF0, 9'b111_1_11111, jmp));
      for (int n = 0; n < 3; n++)
         rows.push_back(S(1, 1, 1'($urandom), 16'($urandom), 9'($urandom), jmp));
      rows.push_back(S(1, 0, 0, 16'hFFF1, 9'h045, mk(0, 9'h000, 16'hFFF1, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'hFFF2, 9'h046, mk(1, 9'h046, 16'hFFF2, 0, 0, 0, 0, 0)));
      // redirect arriving together with a stall is held off until the next free edge
      rows.push_back(S(1, 1, 0, 16'h0030, 9'b111_0_11111, mk(1, 9'h046, 16'hFFF2, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0030, 9'b111_0_11111, mk(1, 9'h1DF, 16'h0030, 1, 1, 16'd31, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0031, 9'h047, mk(0, 9'h000, 16'h0031, 0, 0, 0, 0, 0)));
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL jump_stall row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t rows[$];
      out_t got, exp;
      logic [8:0]  ins;
      logic [15:0] pc;
      for (int n = 0; n < 12; n++) begin
         ins = 9'($urandom_range(1, 383));  // op 000..101, never HALT
         pc  = 16'($urandom);
         rows.push_back(S(1, 0, 1'($urandom), pc, ins, mk(1, ins, pc, 0, 0, 0, 0, 0)));
      end
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL back_to_back row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_halt();
      stim_t rows[$];
      out_t got, exp;
      rows.push_back(S(1, 0, 0, 16'h0020, 9'h000, mk(1, 9'h000, 16'h0020, 0, 0, 0, 0, 1)));
      rows.push_back(S(1, 0, 0, 16'h0021, 9'h1FF, mk(0, 9'h000, 16'h0021, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 1, 16'h0022, 9'h183, mk(0, 9'h000, 16'h0022, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0023, 9'h000, mk(0, 9'h000, 16'h0023, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0024, 9'h045, mk(0, 9'h000, 16'h0024, 0, 0, 0, 0, 0)));
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL halt row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_halt_in_flush();
      stim_t rows[$];
      out_t got, exp;
      rows.push_back(S(0, 0, 0, 16'h0000, 9'h000, ZERO));
      rows.push_back(S(1, 0, 0, 16'h0040, 9'b111_1_00010, mk(1, 9'h1E2, 16'h0040, 1, 1, 16'd2, 1, 0)));
      rows.push_back(S(1, 0, 0, 16'h0041, 9'h000, mk(0, 9'h000, 16'h0041, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0042, 9'h045, mk(1, 9'h045, 16'h0042, 0, 0, 0, 0, 0)));
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL halt_in_flush row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_reset_recovery();
      stim_t rows[$];
      out_t got, exp;
      rows.push_back(S(1, 0, 0, 16'h0050, 9'h1FF, mk(1, 9'h1FF, 16'h0050, 1, 1, 16'd31, 1, 0)));
      rows.push_back(S(0, 1, 0, 16'h0051, 9'h045, ZERO));
      rows.push_back(S(1, 0, 0, 16'h0052, 9'h046, mk(1, 9'h046, 16'h0052, 0, 0, 0, 0, 0)));
      rows.push_back(S(1, 0, 0, 16'h0060, 9'h000, mk(1, 9'h000, 16'h0060, 0, 0, 0, 0, 1)));
      rows.push_back(S(1, 0, 0, 16'h0061, 9'h045, mk(0, 9'h000, 16'h0061, 0, 0, 0, 0, 0)));
      rows.push_back(S(0, 0, 0, 16'h0062, 9'h045, ZERO));
      rows.push_back(S(1, 0, 0, 16'h0063, 9'h047, mk(1, 9'h047, 16'h0063, 0, 0, 0, 0, 0)));
      foreach (rows[k]) begin
         drive(rows[k]);
         got = observe();
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_recovery row%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   initial begin
      bus.stall     = 1'b0;
      bus.cond_flag = 1'b0;
      bus.if_pc     = '0;
      bus.if_instr  = '0;
      @(negedge clk);
      test_reset();
      test_branch_taken();
      test_branch_not_taken();
      test_jump_stall();
      test_back_to_back();
      test_halt();
      test_halt_in_flush();
      test_reset_recovery();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
